// File: rtl/sine_nco_pkg.sv
// Shared constants and the elaboration-time sine generator for the NCO.
package sine_nco_pkg;

    localparam int PHASE_W_DEF = 32;
    localparam int LUT_AW_DEF  = 8;
    localparam int OUT_W_DEF   = 18;

    // 1s17 full scale: largest positive magnitude of an 18-bit signed sample.
    localparam int FULL_SCALE  = 131071;

    // The full-cycle phase index is a 2-bit quadrant above the ROM address.
    localparam int QUAD_W      = 2;

    // Quarter-wave entry k, sampled at the half step so the mirrored
    // quadrants reuse every entry exactly once. Evaluated only at elaboration;
    // a Taylor series keeps it independent of simulator math libraries.
    function automatic int qlut_entry(input int k, input int aw, input int fs);
        real pi;
        real x;
        real term;
        real sum;
        pi   = 3.14159265358979323846;
        x    = 2.0 * pi * (real'(k) + 0.5) / real'(2 ** (aw + QUAD_W));
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return int'(real'(fs) * sum);
    endfunction

endpackage

// File: rtl/sine_qlut.sv
// Quarter-wave sine magnitude ROM with a registered read port.
module sine_qlut
    import sine_nco_pkg::*;
#(
    parameter int AW = LUT_AW_DEF,
    parameter int DW = OUT_W_DEF - 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    // NOTE: the table is constant logic, so it has no reset; only the read register below is cleared.
    logic [DW-1:0] rom_w [2**AW];

    for (genvar k = 0; k < 2**AW; k++) begin : g_rom
        localparam int ENTRY = qlut_entry(k, AW, FULL_SCALE);
        assign rom_w[k] = DW'(ENTRY);
    end

    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    // Table lookup for the addressed entry.
    always_comb begin
        data_d = rom_w[addr];
    end

    // Synchronous read register.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/sine_nco.sv
// Numerically controlled oscillator: phase accumulator, quarter-wave ROM
// with mirror/negate reconstruction, four pipeline stages, strobed samples.
module sine_nco
    import sine_nco_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int LUT_AW  = LUT_AW_DEF,
    parameter int OUT_W   = OUT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_en,
    input  logic [PHASE_W-1:0] fcw_in,
    input  logic               fcw_load,
    input  logic [PHASE_W-1:0] phase_off,
    input  logic               phase_clr,
    output logic [OUT_W-1:0]   y,
    output logic               y_valid
);

    localparam int IDX_W = LUT_AW + QUAD_W;
    localparam int MAG_W = OUT_W - 1;

    // Stage 1 state. Only the index bits of the offset phase are kept,
    // since nothing downstream looks at the fractional phase.
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] fcw_q, fcw_d;
    logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
    logic               v1_q, v1_d;

    // Stage 2 state.
    logic [LUT_AW-1:0]  s2_addr_q, s2_addr_d;
    logic               s2_neg_q, s2_neg_d;
    logic               v2_q, v2_d;

    // Stage 3 state (magnitude register lives in the ROM).
    logic [MAG_W-1:0]   s3_mag;
    logic               s3_neg_q, s3_neg_d;
    logic               v3_q, v3_d;

    // Stage 4 state.
    logic [OUT_W-1:0]   y_q, y_d;
    logic               y_valid_q, y_valid_d;

    logic [PHASE_W-1:0] acc_base;
    logic [QUAD_W-1:0]  quad;
    logic [LUT_AW-1:0]  qaddr;
    logic [OUT_W-1:0]   mag_ext;

    // Stage 1: FCW register, phase accumulator and offset phase index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        fcw_d    = fcw_load ? fcw_in : fcw_q;
        acc_base = phase_clr ? '0 : acc_q;
        acc_d    = acc_base;
        s1_idx_d = s1_idx_q;
        v1_d     = sample_en;
        if (sample_en) begin
            // The increment uses the FCW held before this cycle's load.
            acc_d    = acc_base + fcw_q;
            s1_idx_d = IDX_W'((acc_base + phase_off) >> (PHASE_W - IDX_W));
        end
    end

    // Stage 2: fold the quadrant onto the quarter-wave address and sign.
    always_comb begin
        quad      = s1_idx_q[IDX_W-1 -: QUAD_W];
        qaddr     = s1_idx_q[LUT_AW-1:0];
        s2_addr_d = quad[0] ? ~qaddr : qaddr;
        s2_neg_d  = quad[1];
        v2_d      = v1_q;
    end

    sine_qlut #(
        .AW (LUT_AW),
        .DW (MAG_W)
    ) u_qlut (
        .clk   (clk),
        .reset (reset),
        .addr  (s2_addr_q),
        .data  (s3_mag)
    );

    // Stage 3: carry sign and valid alongside the ROM read.
    always_comb begin
        s3_neg_d = s2_neg_q;
        v3_d     = v2_q;
    end

    // Stage 4: apply sign; hold the output between samples.
    always_comb begin
        mag_ext   = {1'b0, s3_mag};
        y_d       = y_q;
        y_valid_d = v3_q;
        if (v3_q) begin
            y_d = s3_neg_q ? -mag_ext : mag_ext;
        end
    end

    // Pipeline registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            fcw_q     <= '0;
            s1_idx_q  <= '0;
            v1_q      <= 1'b0;
            s2_addr_q <= '0;
            s2_neg_q  <= 1'b0;
            v2_q      <= 1'b0;
            s3_neg_q  <= 1'b0;
            v3_q      <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            acc_q     <= acc_d;
            fcw_q     <= fcw_d;
            s1_idx_q  <= s1_idx_d;
            v1_q      <= v1_d;
            s2_addr_q <= s2_addr_d;
            s2_neg_q  <= s2_neg_d;
            v2_q      <= v2_d;
            s3_neg_q  <= s3_neg_d;
            v3_q      <= v3_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule
